// File: rtl/ariane_ace.sv
// ACE snoop-channel bundles (AC/CR/CD) exchanged with each cache's snoop port.
// Latency: n/a (types only).
// Backpressure: valid/ready per channel, carried inside the bundles.
package ariane_ace;

    typedef struct packed {
        logic [63:0]          addr;
        snoop_pkg::acsnoop_t  snoop;
        logic [2:0]           prot;
    } ac_chan_t;

    typedef struct packed {
        logic wasUnique;
        logic isShared;
        logic passDirty;
        logic error;
        logic dataTransfer;
    } cr_resp_t;

    typedef struct packed {
        logic [snoop_pkg::SnoopBeatWidth-1:0] data;
        logic                                 last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        cr_resp_t cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;

endpackage

// File: rtl/snoop_pkg.sv
// Shared types for the coherent snoop initiator: request opcodes, merged result, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snoop_pkg;

    localparam int SnoopLineBeats = 2;
    localparam int SnoopBeatWidth = 64;
    localparam int SnoopLineWidth = SnoopLineBeats * SnoopBeatWidth;

    typedef enum logic [3:0] {
        READ_ONCE     = 4'b0000,
        READ_SHARED   = 4'b0001,
        READ_UNIQUE   = 4'b0111,
        CLEAN_INVALID = 4'b1001
    } acsnoop_t;

    typedef struct packed {
        logic                      data_valid;
        logic                      is_shared;
        logic                      pass_dirty;
        logic                      error;
        logic [SnoopLineWidth-1:0] data;
    } snoop_result_t;

    typedef enum logic [1:0] {
        IDLE,
        SNOOP,
        COLLECT_CD,
        RESP
    } snoop_state_e;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter; MODE=0 returns the index of the lowest set bit.
// Latency: combinational.
// Backpressure: none.
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Later iterations overwrite earlier ones, so the scan order picks the winner.
    always_comb begin
        cnt_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (MODE) begin
                if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end else begin
                if (in_i[WIDTH-1-i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
        empty_o = ~|in_i;
    end

endmodule

// File: rtl/snoop_initiator.sv
// Broadcasts one snoop to a masked set of caches, merges CR flags and keeps the lowest-index CD line.
// Latency: 3 cycles request-to-result with no data, 5 with a two-beat data transfer.
// Backpressure: one transaction in flight; req_ready_o low until the result is consumed.
module snoop_initiator
    import snoop_pkg::*;
#(
    parameter int unsigned NumPorts = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [63:0]             req_addr_i,
    input  acsnoop_t                req_snoop_i,
    input  logic [NumPorts-1:0]     req_mask_i,
    output ariane_ace::snoop_req_t  snoop_req_o [NumPorts],
    input  ariane_ace::snoop_resp_t snoop_resp_i [NumPorts],
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output snoop_result_t           rsp_o
);

    localparam int unsigned SrcW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    snoop_state_e          state_q;
    logic [63:0]           addr_q;
    acsnoop_t              snoop_q;
    logic [NumPorts-1:0]   ac_pend_q, cr_pend_q, cd_pend_q;
    logic [NumPorts-1:0]   ac_pend_d, cr_pend_d, cd_pend_d;
    logic [SrcW-1:0]       src_q, src_d;
    logic                  src_empty_d;
    logic                  beat_q;
    snoop_result_t         res_q;
    logic                  sh_any, pd_any, err_any;
    logic                  src_hs;
    ariane_ace::cd_chan_t  src_cd;
    logic [NumPorts-1:0]   unused_was_unique;

    // Next-state of the pending vectors; the exit test looks at these so the
    // last CR and the transition happen in the same cycle.
    always_comb begin
        ac_pend_d         = ac_pend_q;
        cr_pend_d         = cr_pend_q;
        cd_pend_d         = cd_pend_q;
        sh_any            = 1'b0;
        pd_any            = 1'b0;
        err_any           = 1'b0;
        unused_was_unique = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            unused_was_unique[i] = snoop_resp_i[i].cr_resp.wasUnique;
            if (state_q == SNOOP) begin
                if (ac_pend_q[i] && snoop_resp_i[i].ac_ready) begin
                    ac_pend_d[i] = 1'b0;
                    cr_pend_d[i] = 1'b1;
                end
                if (cr_pend_q[i] && snoop_resp_i[i].cr_valid) begin
                    cr_pend_d[i] = 1'b0;
                    sh_any  = sh_any  | snoop_resp_i[i].cr_resp.isShared;
                    pd_any  = pd_any  | snoop_resp_i[i].cr_resp.passDirty;
                    err_any = err_any | snoop_resp_i[i].cr_resp.error;
                    if (snoop_resp_i[i].cr_resp.dataTransfer) cd_pend_d[i] = 1'b1;
                end
            end
            if (state_q == COLLECT_CD && cd_pend_q[i] && snoop_resp_i[i].cd_valid
                && snoop_resp_i[i].cd.last) begin
                cd_pend_d[i] = 1'b0;
            end
        end
    end

    lzc #(
        .WIDTH (NumPorts),
        .MODE  (1'b0)
    ) i_src_lzc (
        .in_i    (cd_pend_d),
        .cnt_o   (src_d),
        .empty_o (src_empty_d)
    );

    assign src_cd = snoop_resp_i[src_q].cd;
    assign src_hs = snoop_resp_i[src_q].cd_valid && cd_pend_q[src_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            snoop_q   <= READ_ONCE;
            ac_pend_q <= '0;
            cr_pend_q <= '0;
            cd_pend_q <= '0;
            src_q     <= '0;
            beat_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q    <= req_addr_i;
                        snoop_q   <= req_snoop_i;
                        ac_pend_q <= req_mask_i;
                        cr_pend_q <= '0;
                        cd_pend_q <= '0;
                        src_q     <= '0;
                        beat_q    <= 1'b0;
                        res_q     <= '0;
                        state_q   <= (req_mask_i == '0) ? RESP : SNOOP;
                    end
                end
                SNOOP: begin
                    ac_pend_q        <= ac_pend_d;
                    cr_pend_q        <= cr_pend_d;
                    cd_pend_q        <= cd_pend_d;
                    res_q.is_shared  <= res_q.is_shared  | sh_any;
                    res_q.pass_dirty <= res_q.pass_dirty | pd_any;
                    res_q.error      <= res_q.error      | err_any;
                    if (ac_pend_d == '0 && cr_pend_d == '0) begin
                        if (!src_empty_d) begin
                            src_q            <= src_d;
                            res_q.data_valid <= 1'b1;
                            state_q          <= COLLECT_CD;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                COLLECT_CD: begin
                    cd_pend_q <= cd_pend_d;
                    // Non-source responders are drained but their data is dropped.
                    if (src_hs) begin
                        beat_q <= 1'b1;
                        if (!beat_q) begin
                            res_q.data[SnoopBeatWidth-1:0] <= src_cd.data;
                            if (src_cd.last) res_q.error <= 1'b1;
                        end else begin
                            res_q.data[SnoopLineWidth-1:SnoopBeatWidth] <= src_cd.data;
                        end
                    end
                    if (cd_pend_d == '0) state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumPorts; i++) begin
            snoop_req_o[i]          = '0;
            snoop_req_o[i].ac_valid = ac_pend_q[i];
            snoop_req_o[i].ac.addr  = addr_q;
            snoop_req_o[i].ac.snoop = snoop_q;
            snoop_req_o[i].cr_ready = cr_pend_q[i];
            snoop_req_o[i].cd_ready = cd_pend_q[i] && (state_q == COLLECT_CD);
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_o       = res_q;

endmodule

// File: doc/snoop_initiator.md
# snoop_initiator

Interconnect-side initiator for the ACE snoop channel. It takes one coherent-miss request and broadcasts a snoop (AC) to a masked set of data caches. It collects every snoop response (CR) and drains every snoop data transfer (CD). It then returns one merged result: the 128-bit line from the lowest-index cache that supplied data, plus OR-merged isShared/passDirty/error flags. It sits between the coherent master's miss path and the `snoop_port` of each `std_cache_subsystem` instance.

## Interface
- `NumPorts`, default 2: number of snooped caches; must be ≥1.
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `req_valid_i`  in  1: snoop request valid.
- `req_ready_o`  out  1: request accepted when both valid and ready are high.
- `req_addr_i`  in  64: line address, driven unchanged onto `ac.addr`.
- `req_snoop_i`  in  `snoop_pkg::acsnoop_t`: READ_ONCE, READ_SHARED, READ_UNIQUE or CLEAN_INVALID.
- `req_mask_i`  in  NumPorts: caches to snoop. The requester's own bit is cleared.
- `snoop_req_o`  out  `ariane_ace::snoop_req_t [NumPorts]`: carries `ac_valid`, `ac`, `cr_ready`, `cd_ready`.
- `snoop_resp_i`  in  `ariane_ace::snoop_resp_t [NumPorts]`: carries `ac_ready`, `cr_valid`, `cr_resp`, `cd_valid`, `cd`.
- `rsp_valid_o`  out  1: merged result valid.
- `rsp_ready_i`  in  1: result consumed.
- `rsp_o`  out  `snoop_pkg::snoop_result_t`: fields `data_valid`, `is_shared`, `pass_dirty`, `error`, `data[127:0]`.

## Operation
- FSM states: IDLE, SNOOP, COLLECT_CD, RESP.
- IDLE
  - `req_ready_o`=1.
  - On handshake: latch addr, snoop and mask.
  - Load `ac_pend`=mask. Clear `cr_pend`, `cd_pend`, result and the beat counter.
  - If mask=0, go to RESP with an all-zero result. Otherwise go to SNOOP.
- SNOOP
  - `ac_valid[i]`=`ac_pend[i]`. `ac.addr` and `ac.snoop` come from the latched values; other `ac` fields are 0.
  - On `ac_ready[i]`: clear `ac_pend[i]` and set `cr_pend[i]`.
  - `cr_ready[i]`=`cr_pend[i]`. A CR is never accepted in the same cycle as its own AC.
  - On a CR handshake from port i:
    - clear `cr_pend[i]`;
    - OR `isShared`, `passDirty` and `error` into the result;
    - if `dataTransfer`, set `cd_pend[i]`.
  - Exit when `ac_pend` and `cr_pend` are both zero after this cycle's updates.
    - If `cd_pend`≠0: select src = lowest set index of `cd_pend`, set `data_valid`=1, go to COLLECT_CD.
    - Otherwise go to RESP.
- COLLECT_CD
  - `cd_ready[i]`=`cd_pend[i]` for every pending port. Every data-supplying cache is drained; only src's data is kept.
  - src beat 0 goes to `data[63:0]`, beat 1 to `data[127:64]`. A 1-bit beat counter tracks src only.
  - On a CD handshake with `cd.last`, clear `cd_pend[i]`.
  - If src signals `last` on beat 0, set `error`=1 and leave `data[127:64]`=0.
  - When `cd_pend`=0, go to RESP.
- RESP
  - `rsp_valid_o`=1 and `rsp_o` is held stable.
  - On `rsp_ready_i`, go to IDLE.
- `cd_ready` stays 0 outside COLLECT_CD. Responders hold `cd_valid`; this cannot deadlock because each responder has already completed its CR.
- Reset, including mid-transaction: go to IDLE and clear all registers. All outputs are 0 except `req_ready_o`=1.

## Timing
- Every output is a function of registers only. There is no combinational input-to-output path.
- Minimum latency with no data: handshake at c0; `ac_valid` at c1 with `ac_ready` at c1; `cr_ready` at c2 with CR at c2; `rsp_valid_o` at c3.
- Minimum latency with data: beats at c3 and c4; `rsp_valid_o` at c5.
- AC handshakes on different ports complete independently, in any order or cycle.
- At most one transaction is outstanding. `req_ready_o`=0 outside IDLE.

## Structure
- The following go in `snoop_pkg`:
  - the `snoop_result_t` typedef;
  - a `SnoopLineBeats`=2 constant;
  - a `SnoopBeatWidth`=64 constant.
- Lowest-index source selection uses the common_cells `lzc` sub-module (trailing-zero mode, WIDTH=NumPorts). No other sub-modules.

## Test plan
- NumPorts=2, mask=2'b11, READ_ONCE. Both caches miss (CR=0). Expect: `rsp_o` all 0 at c3, 2 AC and 2 CR handshakes, no CD.
- READ_SHARED. Port1 returns `dataTransfer`=1, `isShared`=1 with beats 64'hA, 64'hB. Expect: `data`=128'h…B_…A, `data_valid`=1, `is_shared`=1.
- READ_SHARED. Both ports return data, port0 = 0x11/0x22 and port1 = 0x33/0x44. Expect: `data` comes from port0, all four beats are drained, and the FSM returns to IDLE.
- READ_UNIQUE. Port0 `ac_ready` is delayed 5 cycles and port1 returns `passDirty`=1. Expect: port1 CR is accepted before port0 AC; `pass_dirty`=1.
- mask=0. Expect: no AC is driven and `rsp_valid_o` is asserted the cycle after the request.
- `rst_ni` is pulled low during COLLECT_CD. Expect: all `cd_ready` and `rsp_valid_o` go to 0 immediately, `req_ready_o`=1 after release, and the next request completes normally.
